// File: rtl/cell_update_engine.sv
// Game-of-Life next-state engine: reads a cell and its in-field neighbours one per
// cycle from a 1-cycle sync RAM, counts live neighbours and applies B3/S23.

module get_nbrs_address #(
  parameter  int unsigned FIELD_W    = 64,
  parameter  int unsigned FIELD_H    = 48,
  localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0]      cell_x,
  input  logic [Y_ADR_SIZE-1:0]      cell_y,
  output logic [7:0]                 rlvnt_c,
  output logic [7:0][X_ADR_SIZE-1:0] nbr_x_c,
  output logic [7:0][Y_ADR_SIZE-1:0] nbr_y_c
);
  localparam logic [X_ADR_SIZE-1:0] X_ONE = X_ADR_SIZE'(1);
  localparam logic [Y_ADR_SIZE-1:0] Y_ONE = Y_ADR_SIZE'(1);
  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

  logic has_l, has_r, has_u, has_d;
  logic [X_ADR_SIZE-1:0] xl, xr;
  logic [Y_ADR_SIZE-1:0] yu, yd;

  // Order: 0..2 row above (L,C,R), 3 left, 4 right, 5..7 row below (L,C,R)
  always_comb begin
    has_l = (cell_x != '0);
    has_r = (cell_x != X_MAX);
    has_u = (cell_y != '0);
    has_d = (cell_y != Y_MAX);
    xl    = cell_x - X_ONE;
    xr    = cell_x + X_ONE;
    yu    = cell_y - Y_ONE;
    yd    = cell_y + Y_ONE;

    rlvnt_c = '0;
    nbr_x_c = '0;
    nbr_y_c = '0;

    rlvnt_c[0] = has_u & has_l;  nbr_x_c[0] = xl;     nbr_y_c[0] = yu;
    rlvnt_c[1] = has_u;          nbr_x_c[1] = cell_x; nbr_y_c[1] = yu;
    rlvnt_c[2] = has_u & has_r;  nbr_x_c[2] = xr;     nbr_y_c[2] = yu;
    rlvnt_c[3] = has_l;          nbr_x_c[3] = xl;     nbr_y_c[3] = cell_y;
    rlvnt_c[4] = has_r;          nbr_x_c[4] = xr;     nbr_y_c[4] = cell_y;
    rlvnt_c[5] = has_d & has_l;  nbr_x_c[5] = xl;     nbr_y_c[5] = yd;
    rlvnt_c[6] = has_d;          nbr_x_c[6] = cell_x; nbr_y_c[6] = yd;
    rlvnt_c[7] = has_d & has_r;  nbr_x_c[7] = xr;     nbr_y_c[7] = yd;
  end
endmodule

module cell_update_engine #(
  parameter  int unsigned FIELD_W    = 64,
  parameter  int unsigned FIELD_H    = 48,
  localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
  output logic                  o_ready,
  output logic                  o_rd_en,
  output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
  input  logic                  i_rd_data,
  output logic                  o_done,
  output logic                  o_next_state,
  output logic [3:0]            o_nbrs_cnt
);
  typedef enum logic [2:0] {IDLE, READ_C, SCAN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {P_NONE, P_CENTRE, P_NBR} pend_t;

  state_t                  state;
  pend_t                   pend;    // tag of the read issued this cycle
  pend_t                   pend_d;  // tag of the data on i_rd_data this cycle
  logic [2:0]              k;
  logic [2:0]              nxt_k;
  logic [X_ADR_SIZE-1:0]   cell_x;
  logic [Y_ADR_SIZE-1:0]   cell_y;
  logic                    centre;
  logic [3:0]              cnt;
  logic                    centre_c;
  logic [3:0]              cnt_c;
  logic [7:0]              rlvnt_c;
  logic [7:0][X_ADR_SIZE-1:0] nbr_x_c;
  logic [7:0][Y_ADR_SIZE-1:0] nbr_y_c;

  get_nbrs_address #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) u_nbrs (
    .cell_x  (cell_x),
    .cell_y  (cell_y),
    .rlvnt_c (rlvnt_c),
    .nbr_x_c (nbr_x_c),
    .nbr_y_c (nbr_y_c)
  );

  // Fold the returning read data into centre/count; next scan index
  always_comb begin
    cnt_c    = cnt;
    centre_c = centre;
    nxt_k    = 3'd0;
    if (pend_d == P_NBR && i_rd_data) cnt_c = cnt + 4'd1;
    if (pend_d == P_CENTRE)           centre_c = i_rd_data;
    if (state == SCAN)                nxt_k = k + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      pend         <= P_NONE;
      pend_d       <= P_NONE;
      k            <= 3'd0;
      cell_x       <= '0;
      cell_y       <= '0;
      centre       <= 1'b0;
      cnt          <= 4'd0;
      o_ready      <= 1'b1;
      o_rd_en      <= 1'b0;
      o_rd_x_adr   <= '0;
      o_rd_y_adr   <= '0;
      o_done       <= 1'b0;
      o_next_state <= 1'b0;
      o_nbrs_cnt   <= 4'd0;
    end else begin
      cnt    <= cnt_c;
      centre <= centre_c;
      pend_d <= pend;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= READ_C;
            o_ready    <= 1'b0;
            cell_x     <= i_cell_x_adr;
            cell_y     <= i_cell_y_adr;
            cnt        <= 4'd0;
            o_rd_en    <= 1'b1;
            o_rd_x_adr <= i_cell_x_adr;
            o_rd_y_adr <= i_cell_y_adr;
            pend       <= P_CENTRE;
          end
        end
        READ_C, SCAN: begin
          if (state == SCAN && k == 3'd7) begin
            state   <= DRAIN;
            o_rd_en <= 1'b0;
            pend    <= P_NONE;
          end else begin
            // Irrelevant neighbours still take their slot; address holds
            state   <= SCAN;
            k       <= nxt_k;
            o_rd_en <= rlvnt_c[nxt_k];
            if (rlvnt_c[nxt_k]) begin
              o_rd_x_adr <= nbr_x_c[nxt_k];
              o_rd_y_adr <= nbr_y_c[nxt_k];
              pend       <= P_NBR;
            end else begin
              pend       <= P_NONE;
            end
          end
        end
        DRAIN: begin
          state        <= DONE;
          o_done       <= 1'b1;
          o_next_state <= (cnt_c == 4'd3) | (centre_c & (cnt_c == 4'd2));
          o_nbrs_cnt   <= cnt_c;
        end
        DONE: begin
          state   <= IDLE;
          o_done  <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cell_update_engine.sv
// Directed bench for cell_update_engine on a 4x3 field with a 1-cycle RAM model
// and a scoreboard of expected counts, read addresses and latency.

module tb_cell_update_engine;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct {
    int x;
    int y;
    int cnt;
    int nxt;
    int reads;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cx;
  logic [1:0] cy;
  logic       ready;
  logic       rd_en;
  logic [1:0] rd_x;
  logic [1:0] rd_y;
  logic       rd_data;
  logic       done;
  logic       next_state;
  logic [3:0] nbrs_cnt;

  logic fld [0:H-1][0:W-1];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   dones = 0;
  int   lat   = 0;
  int   rd_cnt = 0;
  int   dxs [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int   dys [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int   ex, ey, rel;
  exp_t e;

  cell_update_engine #(.FIELD_W(W), .FIELD_H(H)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_cell_x_adr (cx),
    .i_cell_y_adr (cy),
    .o_ready      (ready),
    .o_rd_en      (rd_en),
    .o_rd_x_adr   (rd_x),
    .o_rd_y_adr   (rd_y),
    .i_rd_data    (rd_data),
    .o_done       (done),
    .o_next_state (next_state),
    .o_nbrs_cnt   (nbrs_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 1-cycle read field memory
  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_y < 2'd3) ? fld[rd_y][rd_x] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t r;
    r.x = x; r.y = y; r.cnt = 0; r.reads = 1;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H) begin
          r.reads++;
          if (fld[y + dy][x + dx]) r.cnt++;
        end
      end
    end
    r.nxt = (r.cnt == 3 || (fld[y][x] && r.cnt == 2)) ? 1 : 0;
    return r;
  endfunction

  task automatic set_all(input logic v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fld[y][x] = v;
  endtask

  task automatic set_blinker();
    set_all(1'b0);
    fld[0][1] = 1'b1;
    fld[1][1] = 1'b1;
    fld[2][1] = 1'b1;
  endtask

  // Scoreboard monitor: per-cycle read pattern and result at o_done
  always @(negedge clk) begin
    if (!rst_n || ready) begin
      lat    = 0;
      rd_cnt = 0;
    end else begin
      lat++;
      if (rd_en) rd_cnt++;
      if (sb.size() > 0) begin
        e = sb[0];
        if (lat <= 9) begin
          if (lat == 1) begin
            ex = e.x; ey = e.y; rel = 1;
          end else begin
            ex  = e.x + dxs[lat-2];
            ey  = e.y + dys[lat-2];
            rel = (ex >= 0 && ex < W && ey >= 0 && ey < H) ? 1 : 0;
          end
          check($sformatf("rd_en c%0d", lat), 32'(rd_en), 32'(rel));
          if (rel == 1 && rd_en) begin
            check($sformatf("rd_x c%0d", lat), 32'(rd_x), 32'(ex));
            check($sformatf("rd_y c%0d", lat), 32'(rd_y), 32'(ey));
          end
        end
        if (lat == 11) check("done_pulse", 32'(done), 32'd1);
        if (done) begin
          dones++;
          check("latency", 32'(lat), 32'd11);
          check("nbrs_cnt", 32'(nbrs_cnt), 32'(e.cnt));
          check("next_state", 32'(next_state), 32'(e.nxt));
          check("reads", 32'(rd_cnt), 32'(e.reads));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20 && dones == d0; i++) @(negedge clk);
    check("done_seen", 32'(dones - d0), 32'd1);
  endtask

  task automatic req(input int x, input int y);
    int d0;
    @(negedge clk);
    check("ready_idle", 32'(ready), 32'd1);
    sb.push_back(model(x, y));
    d0    = dones;
    start = 1'b1;
    cx    = 2'(x);
    cy    = 2'(y);
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ready"}, 32'(ready), 32'd1);
    check({pfx, "_rd_en"}, 32'(rd_en), 32'd0);
    check({pfx, "_rd_x"}, 32'(rd_x), 32'd0);
    check({pfx, "_rd_y"}, 32'(rd_y), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_next"}, 32'(next_state), 32'd0);
    check({pfx, "_cnt"}, 32'(nbrs_cnt), 32'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    cx    = 2'd0;
    cy    = 2'd0;
    set_all(1'b1);
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // All cells alive: corner, interior, edge
    req(0, 0);
    check("corner_cnt", 32'(nbrs_cnt), 32'd3);
    check("corner_next", 32'(next_state), 32'd1);
    req(1, 1);
    check("interior_cnt", 32'(nbrs_cnt), 32'd8);
    check("interior_next", 32'(next_state), 32'd0);
    req(3, 1);
    check("edge_cnt", 32'(nbrs_cnt), 32'd5);

    // Vertical blinker at x=1
    set_blinker();
    req(0, 1);
    check("blk01_cnt", 32'(nbrs_cnt), 32'd3);
    check("blk01_next", 32'(next_state), 32'd1);
    req(1, 1);
    check("blk11_cnt", 32'(nbrs_cnt), 32'd2);
    check("blk11_next", 32'(next_state), 32'd1);
    req(1, 0);
    check("blk10_cnt", 32'(nbrs_cnt), 32'd1);
    check("blk10_next", 32'(next_state), 32'd0);

    // Empty field, far corner
    set_all(1'b0);
    req(3, 2);
    check("empty_cnt", 32'(nbrs_cnt), 32'd0);
    check("empty_next", 32'(next_state), 32'd0);

    // Extra i_start pulses during a request are ignored
    set_blinker();
    @(negedge clk);
    sb.push_back(model(0, 1));
    d0 = dones;
    start = 1'b1; cx = 2'd0; cy = 2'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; cx = 2'd3; cy = 2'd2;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(d0);
    repeat (4) @(negedge clk);
    check("single_done", 32'(dones - d0), 32'd1);
    check("hold_cnt", 32'(nbrs_cnt), 32'd3);
    check("hold_next", 32'(next_state), 32'd1);
    check("hold_ready", 32'(ready), 32'd1);
    req(1, 0);
    check("after_pulse_cnt", 32'(nbrs_cnt), 32'd1);

    // Asynchronous reset mid-request
    @(negedge clk);
    sb.push_back(model(1, 1));
    d0 = dones;
    start = 1'b1; cx = 2'd1; cy = 2'd1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    sb.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(dones - d0), 32'd0);
    rst_n = 1'b1;
    req(2, 1);
    check("post_rst_cnt", 32'(nbrs_cnt), 32'd3);
    check("post_rst_next", 32'(next_state), 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
